// File: rtl/la_capture_ctrl.sv
`timescale 1ns/1ps
// Logic-analyser capture controller: writes strobed probe samples into a circular
// RAM, qualifies a masked pattern trigger and keeps a programmable pre-trigger window.
module la_capture_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    // state     | meaning
    // IDLE      | not capturing, waiting for arm
    // PRE       | filling the pre-trigger window, trigger not evaluated
    // WAIT_TRIG | circular capture while looking for the pattern
    // POST      | capturing the remainder of the buffer after the trigger
    // DONE      | buffer complete, addresses valid for readout
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pre_len_q;
    logic [ADDR_W-1:0] cnt, cnt_n, cnt_inc;
    logic [ADDR_W-1:0] post_len;
    logic              capturing;
    logic              sample;
    logic              hit;
    logic              do_arm;
    logic              do_trig;

    assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    assign sample    = capturing && sample_en && !abort;
    assign hit       = ((din ^ trig_value) & trig_mask) == '0;
    assign cnt_inc   = cnt + ONE;
    // DEPTH-1-pre_len_q is the bitwise complement within ADDR_W bits
    assign post_len  = ~pre_len_q;
    assign busy      = capturing;
    assign done      = (state == DONE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        do_arm  = 1'b0;
        do_trig = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        do_arm  = 1'b1;
                        cnt_n   = '0;
                        state_n = (pre_len != '0) ? PRE : WAIT_TRIG;
                    end
                end
                PRE: begin
                    if (sample_en) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == pre_len_q) state_n = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (sample_en && hit) begin
                        do_trig = 1'b1;
                        cnt_n   = '0;
                        state_n = (post_len == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (sample_en) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == post_len) state_n = DONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            pre_len_q  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            wr_en <= sample;
            if (sample) begin
                wr_addr <= wr_ptr;
                wr_data <= din;
                wr_ptr  <= wr_ptr + ONE;
            end
            if (do_arm) begin
                wr_ptr    <= '0;
                pre_len_q <= pre_len;
                triggered <= 1'b0;
            end
            if (abort) begin
                triggered <= 1'b0;
            end
            if (do_trig) begin
                triggered  <= 1'b1;
                trig_addr  <= wr_ptr;
                start_addr <= wr_ptr - pre_len_q;
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for la_capture_ctrl at DEPTH=16: stimulus queues expected RAM
// writes, an independent monitor pops and compares them as wr_en appears.
module tb_la_capture_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          sample_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] trig_mask = '0;
    logic [DW-1:0] trig_value = '0;
    logic [AW-1:0] pre_len = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          triggered;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;

    la_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .sample_en(sample_en),
        .din(din), .trig_mask(trig_mask), .trig_value(trig_value), .pre_len(pre_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .triggered(triggered), .trig_addr(trig_addr), .start_addr(start_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every write must match the head of the queue in address, data and cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_wr_en", wr_en, 0);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("wr_latency", cyc, e.cyc);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                check("missing_wr_en", wr_en, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic push_exp(input int idx);
        exp_t e;
        e.addr = idx[AW-1:0];
        e.data = idx[DW-1:0];
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    // one strobe every 4 clocks; din carries the sample index since arm
    task automatic strobe(input bit expect_wr, input int idx);
        @(negedge clk);
        din       = idx[DW-1:0];
        sample_en = 1'b1;
        if (expect_wr) push_exp(idx);
        @(negedge clk);
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_arm(input logic [DW-1:0] m, input logic [DW-1:0] v, input logic [AW-1:0] pl);
        @(negedge clk);
        trig_mask  = m;
        trig_value = v;
        pre_len    = pl;
        arm        = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic run_capture(input string name, input int n,
                               input logic [AW-1:0] exp_trig, input logic [AW-1:0] exp_start);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                check({name, "_busy_before_last"}, busy, 1);
                check({name, "_done_before_last"}, done, 0);
            end
            strobe(1'b1, i);
        end
        check({name, "_done"}, done, 1);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_triggered"}, triggered, 1);
        check({name, "_trig_addr"}, trig_addr, exp_trig);
        check({name, "_start_addr"}, start_addr, exp_start);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_triggered", triggered, 0);
        rst = 1'b0;
        strobe(1'b0, 0);
        check("idle_busy", busy, 0);

        // immediate trigger
        do_arm(8'h00, 8'h00, 4'd0);
        run_capture("immediate", 16, 4'd0, 4'd0);
        strobe(1'b0, 16);
        check("done_held", done, 1);

        // pattern 0x20 with 4 pre-trigger samples
        do_arm(8'hFF, 8'h20, 4'd4);
        check("arm_clears_done", done, 0);
        check("arm_clears_triggered", triggered, 0);
        run_capture("pattern", 44, 4'd0, 4'd12);

        // 0x02 occurs in PRE and must be ignored; wraps to 0x102
        do_arm(8'hFF, 8'h02, 4'd4);
        run_capture("pre_ignore", 270, 4'd2, 4'd14);

        // maximum pre-trigger: DONE on the trigger strobe itself
        do_arm(8'hFF, 8'h13, 4'd15);
        run_capture("clamp", 20, 4'd3, 4'd4);

        // abort during POST; the registered write still lands
        do_arm(8'h00, 8'h00, 4'd0);
        for (int i = 0; i < 4; i++) strobe(1'b1, i);
        @(negedge clk);
        din = 8'h04;
        sample_en = 1'b1;
        push_exp(4);
        @(negedge clk);
        sample_en = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_triggered", triggered, 0);
        strobe(1'b0, 5);

        // re-arm restarts at address 0; abort beats a coincident strobe
        do_arm(8'h00, 8'h00, 4'd0);
        strobe(1'b1, 0);
        strobe(1'b1, 1);
        @(negedge clk);
        din = 8'h02;
        sample_en = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        abort = 1'b0;
        check("abort_vs_strobe_busy", busy, 0);

        // arm while in WAIT_TRIG is ignored
        do_arm(8'hFF, 8'h05, 4'd0);
        for (int i = 0; i < 3; i++) strobe(1'b1, i);
        do_arm(8'hFF, 8'h05, 4'd0);
        check("rearm_busy", busy, 1);
        for (int i = 3; i < 6; i++) strobe(1'b1, i);
        check("waittrig_triggered", triggered, 1);
        check("waittrig_trig_addr", trig_addr, 5);
        check("waittrig_start_addr", start_addr, 5);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort2_triggered", triggered, 0);

        // arm and abort together stay in IDLE
        @(negedge clk);
        arm = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", busy, 0);
        check("arm_abort_done", done, 0);
        strobe(1'b0, 0);

        // asynchronous reset in WAIT_TRIG while a write is on the bus
        do_arm(8'hFF, 8'hAA, 4'd0);
        strobe(1'b1, 0);
        @(negedge clk);
        din = 8'h01;
        sample_en = 1'b1;
        push_exp(1);
        @(posedge clk);
        #2;
        sample_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_wr_en", wr_en, 0);
        check("rst_async_wr_addr", wr_addr, 0);
        check("rst_async_wr_data", wr_data, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_trig_addr", trig_addr, 0);
        check("rst_async_start_addr", start_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        strobe(1'b0, 2);
        check("post_rst_busy", busy, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Logic-analyser capture controller. It is the consumer of the divided sample strobe (one-cycle `sample_en` pulses produced by the sample-rate divider).
- On each strobe, while armed, it samples the probe bus and writes it into a circular capture RAM.
- It qualifies a pattern trigger and retains a programmable number of pre-trigger samples.
- It stops after filling the buffer and reports the trigger and start addresses to the readout logic.

Parameters:
- DATA_W, 8, probe channel count / RAM word width
- ADDR_W, 10, capture RAM address width; DEPTH = 2^ADDR_W samples

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle start pulse; ignored unless state is IDLE or DONE
- abort  in  1  forces return to IDLE from any state
- sample_en  in  1  sample strobe from the divider, at most one cycle wide
- din  in  DATA_W  probe inputs, already synchronised
- trig_mask  in  DATA_W  1 = bit participates in the trigger; all-zero = immediate trigger
- trig_value  in  DATA_W  pattern compared under the mask
- pre_len  in  ADDR_W  pre-trigger sample count, latched on arm
- wr_en  out  1  capture RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- busy  out  1  high in PRE, WAIT_TRIG and POST
- done  out  1  high in DONE; held until the next arm, abort or rst
- triggered  out  1  high from the trigger sample until the next arm, abort or rst
- trig_addr  out  ADDR_W  RAM address holding the trigger sample
- start_addr  out  ADDR_W  address of the oldest valid sample = trig_addr - pre_len_q mod DEPTH

Behaviour:
- Reset values: wr_en, busy, done and triggered are 0; wr_addr, wr_data, trig_addr and start_addr are 0; state is IDLE; wr_ptr is 0.
- State encoding: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4.
- On arm in IDLE or DONE:
  - wr_ptr clears to 0.
  - pre_len_q latches min(pre_len, DEPTH-1); all-ones ADDR_W is the maximum value.
  - cnt clears to 0; done and triggered clear.
  - Next state is PRE if pre_len_q != 0, otherwise WAIT_TRIG.
- Sampling rule: in PRE, WAIT_TRIG and POST, each cycle with sample_en=1 is a "sample cycle".
  - On a sample cycle, the next cycle has wr_en=1, wr_addr=wr_ptr and wr_data=din from the sample cycle (registered, 1-cycle latency).
  - wr_ptr then increments and wraps from DEPTH-1 to 0.
  - Outside sample cycles, wr_en=0.
  - sample_en is ignored in IDLE and DONE.
- PRE:
  - Counts sample cycles in cnt.
  - After pre_len_q samples have been written, go to WAIT_TRIG.
  - Trigger is not evaluated in PRE.
- WAIT_TRIG:
  - On each sample cycle, hit = ((din ^ trig_value) & trig_mask) == 0.
  - On a miss: the sample is written and circular overwriting continues.
  - On a hit: the sample is written; trig_addr <= wr_ptr; start_addr <= wr_ptr - pre_len_q (mod DEPTH); triggered <= 1; cnt clears; go to POST.
- POST:
  - Writes exactly DEPTH-1-pre_len_q further samples.
  - On the sample cycle of the last of these, go to DONE.
  - If DEPTH-1-pre_len_q = 0 (pre_len_q = DEPTH-1), go directly from WAIT_TRIG to DONE on the trigger hit.
- DONE: no writes. done=1 until the next arm (re-arm allowed), abort or rst.
- Buffer contents in DONE: exactly DEPTH samples, from start_addr to start_addr+DEPTH-1 (mod DEPTH). The trigger sample sits at offset pre_len_q.
- abort:
  - Next state is IDLE; done and triggered clear.
  - A write already registered from the previous sample cycle still completes.
  - abort has priority over arm and over sample_en in the same cycle.
- arm while busy: ignored.
- Reset mid-capture: outputs return to reset values immediately; no further writes.
- cnt is ADDR_W bits wide; all address arithmetic is modulo DEPTH.

Test Plan (ADDR_W=4, DEPTH=16, DATA_W=8; din increments by 1 on every sample_en, starting at 0x00):
- Immediate trigger: trig_mask=0x00, pre_len=0, arm, strobe every 4 clk.
  - Expected: din=0x00 is the trigger, trig_addr=0, start_addr=0.
  - 16 writes with data 0x00..0x0F at addresses 0..15; done after the 16th; wr_en lags each strobe by 1 cycle.
- Pattern with pre-trigger: mask=0xFF, value=0x20, pre_len=4.
  - Expected: 0x20 is written at addr 0 (32 mod 16), trig_addr=0, start_addr=12.
  - 11 post samples (0x21..0x2B); done asserts on the 0x2B strobe; buffer holds 0x1C..0x2B.
- Trigger ignored in PRE: value=0x02, mask=0xFF, pre_len=4.
  - Expected: 0x02 does not trigger. Capture continues and triggers at 0x102 (8-bit wrap to 0x02) at addr 2 (258 mod 16).
- Clamp: pre_len=15.
  - Expected: pre_len_q=15; DONE is entered on the trigger strobe itself; start_addr = trig_addr+1 (mod 16).
- Abort and re-arm: abort during POST.
  - Expected: busy=0, done=0 next cycle; no wr_en after the pending one.
  - A re-arm then restarts with wr_ptr=0.
  - Also: arm asserted during WAIT_TRIG has no effect; arm and abort in the same cycle leave the block in IDLE.
- Reset mid-capture: assert rst while in WAIT_TRIG.
  - Expected: all outputs 0 asynchronously, state IDLE; after release, sample_en produces no writes until arm.
